neural_network_top: RTL and testbench
=====================================

Name: neural_network_top

Overview:
- Fully-connected quantized MNIST classifier with topology 784 -> 16 (ReLU) -> 16 (ReLU) -> 10 (linear).
- All data is 16-bit signed fixed point.
- Weights, biases and the image arrive as parallel array ports. The block computes serially, one multiply-accumulate per clock, on a single shared MAC.
- It sits at the top of the inference datapath. A host loads the arrays, pulses start, and waits for valid_out.

Parameters:
- IN_SIZE, 784, input pixels.
- H1_SIZE, 16, first hidden layer width.
- H2_SIZE, 16, second hidden layer width.
- OUT_SIZE, 10, output classes.
- DATA_W, 16, width of every data, weight, bias and result word.
- FRAC_BITS, 8, fractional bits (Q8.8) of all operands and results.
- ACC_W, 48, accumulator width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rstN  in  1  reset: synchronous, active-low.
- start  in  1  one-cycle request to begin an inference.
- input_image  in  signed [15:0] x 784  image pixels, Q8.8.
- fc1_weights  in  signed [15:0] x 12544  layer-1 weights; row-major, w[n*784+i].
- fc2_weights  in  signed [15:0] x 256  layer-2 weights; w[n*16+i].
- fc3_weights  in  signed [15:0] x 160  layer-3 weights; w[n*16+i].
- fc1_biases  in  signed [15:0] x 16  layer-1 biases.
- fc2_biases  in  signed [15:0] x 16  layer-2 biases.
- fc3_biases  in  signed [15:0] x 10  layer-3 biases.
- output_result  out  signed [15:0] x 10  class scores, registered.
- valid_out  out  1  high while output_result holds a completed inference.

Behaviour:
- Reset (rstN low at a clock edge):
  - State goes to IDLE; valid_out is 0; all output_result words and all hidden buffers are 0; counters are 0.
  - Reset takes priority over everything, including mid-inference; a partial inference is discarded.
- States: IDLE, L1, L2, L3, DONE.
- start handling:
  - start is sampled only in IDLE or DONE. Call the sampling edge E0.
  - Accepting start clears valid_out at E0, clears the accumulator and neuron/input counters, and enters L1.
  - start is ignored in L1, L2 and L3.
- Layer processing, per neuron n:
  - N_in MAC edges: acc += sext(x[i]) * sext(w[n*N_in+i]), with the full 32-bit product sign-extended to ACC_W.
  - Then 1 finalize edge:
    - r = (acc >>> FRAC_BITS) + sext(bias[n]) (arithmetic shift, floor).
    - Saturate r to [-32768, 32767].
    - For L1 and L2, apply ReLU (negative -> 0).
    - Write r to the layer buffer (h1[n], h2[n], or output_result[n]).
    - Clear acc and advance n.
  - Layer inputs: L1 uses input_image, L2 uses h1, L3 uses h2.
  - L3 has no ReLU, so output_result may be negative.
- Transitions:
  - L1 -> L2 on the finalize edge of neuron 15.
  - L2 -> L3 on the finalize edge of neuron 15.
  - L3 -> DONE on the finalize edge of neuron 9. valid_out goes to 1 on that same edge.
- Latency:
  - Cost is 785 edges per L1 neuron and 17 edges per L2/L3 neuron.
  - The final write and valid_out rise occur at edge E0+13002 (16*785 + 16*17 + 10*17).
- DONE:
  - output_result and valid_out are held indefinitely until a new start or reset.
  - A start in DONE begins a new inference; previous results remain visible until they are overwritten neuron by neuron.
- Input stability: all array inputs must be held stable from E0 until valid_out. The block does not latch them.
- Intermediate results: output_result words not yet rewritten in L3 are not guaranteed meaningful while valid_out is 0.

Test Plan:
- All weights 0; fc3_biases[k] = k*256; other biases 0; start pulse -> valid_out rises exactly 13002 cycles after E0; output_result[k] = k*256.
- Pass-through: input_image[0] = 0x0100, others 0. fc1 weight w[n*784+0] = 0x0100 for all n. fc2 and fc3 weights identity (w[n*16+n] = 0x0100), all biases 0 -> output_result[k] = 0x0100 for k = 0..9.
- ReLU: as pass-through but fc1_biases = -0x0200, all fc2 and fc3 weights 0x0100, fc2/fc3 biases 0 -> hidden values clamp to 0 -> all outputs 0.
- Saturation and negative outputs:
  - All pixels and fc1 weights 0x7FFF, fc2 and fc3 weights all 0x0100, biases 0 -> every output 32767.
  - Separately, all weights 0 and fc3_biases = -512 -> every output -512 (no ReLU on the last layer).
- Control:
  - Reset asserted at E0+500 -> next edge valid_out = 0 and outputs 0.
  - A start pulse during L2 is ignored (latency unchanged).
  - A new start after DONE clears valid_out and repeats with the same results.

Source files
------------

// File: rtl/neural_network_top.sv
// Quantized 784-16-16-10 MNIST classifier computed serially on one shared MAC.
// Each neuron takes N_in accumulate edges followed by one finalize edge (shift, bias, saturate, ReLU).
module neural_network_top #(
  parameter int IN_SIZE   = 784,
  parameter int H1_SIZE   = 16,
  parameter int H2_SIZE   = 16,
  parameter int OUT_SIZE  = 10,
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 48
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] input_image   [IN_SIZE],
  input  logic signed [DATA_W-1:0] fc1_weights   [H1_SIZE*IN_SIZE],
  input  logic signed [DATA_W-1:0] fc2_weights   [H2_SIZE*H1_SIZE],
  input  logic signed [DATA_W-1:0] fc3_weights   [OUT_SIZE*H2_SIZE],
  input  logic signed [DATA_W-1:0] fc1_biases    [H1_SIZE],
  input  logic signed [DATA_W-1:0] fc2_biases    [H2_SIZE],
  input  logic signed [DATA_W-1:0] fc3_biases    [OUT_SIZE],
  output logic signed [DATA_W-1:0] output_result [OUT_SIZE],
  output logic                     valid_out
);

  localparam int MAX_IN  = (IN_SIZE > H1_SIZE) ? ((IN_SIZE > H2_SIZE) ? IN_SIZE : H2_SIZE)
                                               : ((H1_SIZE > H2_SIZE) ? H1_SIZE : H2_SIZE);
  localparam int MAX_N   = (H1_SIZE > H2_SIZE) ? ((H1_SIZE > OUT_SIZE) ? H1_SIZE : OUT_SIZE)
                                               : ((H2_SIZE > OUT_SIZE) ? H2_SIZE : OUT_SIZE);
  localparam int CNT_W   = $clog2(MAX_IN + 1);
  localparam int N_W     = $clog2(MAX_N);
  localparam int IMG_AW  = $clog2(IN_SIZE);
  localparam int H1_AW   = $clog2(H1_SIZE);
  localparam int H2_AW   = $clog2(H2_SIZE);
  localparam int OUT_AW  = $clog2(OUT_SIZE);
  localparam int W1_AW   = $clog2(H1_SIZE*IN_SIZE);
  localparam int W2_AW   = $clog2(H2_SIZE*H1_SIZE);
  localparam int W3_AW   = $clog2(OUT_SIZE*H2_SIZE);
  localparam int PROD_W  = 2*DATA_W;

  typedef enum logic [2:0] {IDLE, L1, L2, L3, DONE} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] i;
  logic [N_W-1:0]   n;
  logic [CNT_W-1:0] n_in;
  logic [N_W-1:0]   n_last;
  logic             fin;
  logic             last_neuron;

  logic signed [DATA_W-1:0] h1 [H1_SIZE];
  logic signed [DATA_W-1:0] h2 [H2_SIZE];

  logic [W1_AW-1:0] w1_idx;
  logic [W2_AW-1:0] w2_idx;
  logic [W3_AW-1:0] w3_idx;

  logic signed [DATA_W-1:0] x_p0, w_p0, bias_p0;
  logic signed [PROD_W-1:0] prod_p0;
  logic signed [ACC_W-1:0]  prod_ext_p0, bias_ext_p0, r_p0;
  logic signed [ACC_W-1:0]  acc_p1;
  logic signed [DATA_W-1:0] sat_p0;

  function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [ACC_W-1:0] v);
    // In range exactly when every bit from the result MSB upward matches the sign.
    if (&v[ACC_W-1:DATA_W-1] || ~|v[ACC_W-1:DATA_W-1])
      return v[DATA_W-1:0];
    else if (v[ACC_W-1])
      return {1'b1, {(DATA_W-1){1'b0}}};
    else
      return {1'b0, {(DATA_W-1){1'b1}}};
  endfunction

  function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] v);
    return v[DATA_W-1] ? '0 : v;
  endfunction

  assign w1_idx = W1_AW'(n) * W1_AW'(IN_SIZE) + W1_AW'(i);
  assign w2_idx = W2_AW'(n) * W2_AW'(H1_SIZE) + W2_AW'(i);
  assign w3_idx = W3_AW'(n) * W3_AW'(H2_SIZE) + W3_AW'(i);

  // Stage p0: operand/bias select for the current layer, multiply and finalize arithmetic
  always_comb begin
    x_p0    = '0;
    w_p0    = '0;
    bias_p0 = '0;
    n_in    = '0;
    n_last  = '0;
    unique case (state)
      L1: begin
        n_in    = CNT_W'(IN_SIZE);
        n_last  = N_W'(H1_SIZE - 1);
        bias_p0 = fc1_biases[n[H1_AW-1:0]];
        if (i != n_in) begin
          x_p0 = input_image[i[IMG_AW-1:0]];
          w_p0 = fc1_weights[w1_idx];
        end
      end
      L2: begin
        n_in    = CNT_W'(H1_SIZE);
        n_last  = N_W'(H2_SIZE - 1);
        bias_p0 = fc2_biases[n[H2_AW-1:0]];
        if (i != n_in) begin
          x_p0 = h1[i[H1_AW-1:0]];
          w_p0 = fc2_weights[w2_idx];
        end
      end
      L3: begin
        n_in    = CNT_W'(H2_SIZE);
        n_last  = N_W'(OUT_SIZE - 1);
        bias_p0 = fc3_biases[n[OUT_AW-1:0]];
        if (i != n_in) begin
          x_p0 = h2[i[H2_AW-1:0]];
          w_p0 = fc3_weights[w3_idx];
        end
      end
      default: ;
    endcase
  end

  assign fin         = (i == n_in);
  assign last_neuron = (n == n_last);
  assign prod_p0     = x_p0 * w_p0;
  assign prod_ext_p0 = {{(ACC_W-PROD_W){prod_p0[PROD_W-1]}}, prod_p0};
  assign bias_ext_p0 = {{(ACC_W-DATA_W){bias_p0[DATA_W-1]}}, bias_p0};
  assign r_p0        = (acc_p1 >>> FRAC_BITS) + bias_ext_p0;
  assign sat_p0      = sat_data(r_p0);

  always_ff @(posedge clk) begin
    if (!rstN) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (start) state_nxt = L1;
      L1:         if (fin && last_neuron) state_nxt = L2;
      L2:         if (fin && last_neuron) state_nxt = L3;
      L3:         if (fin && last_neuron) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Stage p1: accumulator, counters and layer buffers
  always_ff @(posedge clk) begin
    if (!rstN) begin
      acc_p1    <= '0;
      i         <= '0;
      n         <= '0;
      valid_out <= 1'b0;
      for (int k = 0; k < H1_SIZE; k++)  h1[k] <= '0;
      for (int k = 0; k < H2_SIZE; k++)  h2[k] <= '0;
      for (int k = 0; k < OUT_SIZE; k++) output_result[k] <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            acc_p1    <= '0;
            i         <= '0;
            n         <= '0;
            valid_out <= 1'b0;
          end
        end
        L1, L2, L3: begin
          if (!fin) begin
            acc_p1 <= acc_p1 + prod_ext_p0;
            i      <= i + 1'b1;
          end else begin
            acc_p1 <= '0;
            i      <= '0;
            n      <= last_neuron ? '0 : n + 1'b1;
            if (state == L1) h1[n[H1_AW-1:0]] <= relu(sat_p0);
            if (state == L2) h2[n[H2_AW-1:0]] <= relu(sat_p0);
            if (state == L3) begin
              output_result[n[OUT_AW-1:0]] <= sat_p0;
              if (last_neuron) valid_out <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neural_network_top.sv
// Scoreboard bench for neural_network_top: a floating-free integer reference model computes
// expected class scores per inference; a monitor checks them and the latency when valid_out rises.
module tb_neural_network_top;

  localparam int IN_SIZE  = 784;
  localparam int H1_SIZE  = 16;
  localparam int H2_SIZE  = 16;
  localparam int OUT_SIZE = 10;
  localparam int LATENCY  = 16*785 + 16*17 + 10*17;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic start = 1'b0;
  logic signed [15:0] input_image   [IN_SIZE];
  logic signed [15:0] fc1_weights   [H1_SIZE*IN_SIZE];
  logic signed [15:0] fc2_weights   [H2_SIZE*H1_SIZE];
  logic signed [15:0] fc3_weights   [OUT_SIZE*H2_SIZE];
  logic signed [15:0] fc1_biases    [H1_SIZE];
  logic signed [15:0] fc2_biases    [H2_SIZE];
  logic signed [15:0] fc3_biases    [OUT_SIZE];
  logic signed [15:0] output_result [OUT_SIZE];
  logic               valid_out;

  neural_network_top dut (
    .clk(clk), .rstN(rstN), .start(start),
    .input_image(input_image),
    .fc1_weights(fc1_weights), .fc2_weights(fc2_weights), .fc3_weights(fc3_weights),
    .fc1_biases(fc1_biases), .fc2_biases(fc2_biases), .fc3_biases(fc3_biases),
    .output_result(output_result), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int                       due;
    logic [OUT_SIZE*16-1:0]   res;
  } sb_entry_t;

  sb_entry_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [OUT_SIZE*16-1:0] last_exp;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int rnd(input int lo, input int hi);
    return lo + int'($urandom_range(hi - lo, 0));
  endfunction

  function automatic int sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // Reference: plain dot products with floor shift, bias, clamp and ReLU per layer.
  task automatic model(output logic [OUT_SIZE*16-1:0] res);
    int h1m [H1_SIZE];
    int h2m [H2_SIZE];
    longint acc;
    int r;
    for (int n = 0; n < H1_SIZE; n++) begin
      acc = 0;
      for (int k = 0; k < IN_SIZE; k++)
        acc += longint'(input_image[k]) * longint'(fc1_weights[n*IN_SIZE+k]);
      r = sat16((acc >>> 8) + longint'(fc1_biases[n]));
      h1m[n] = (r < 0) ? 0 : r;
    end
    for (int n = 0; n < H2_SIZE; n++) begin
      acc = 0;
      for (int k = 0; k < H1_SIZE; k++)
        acc += longint'(h1m[k]) * longint'(fc2_weights[n*H1_SIZE+k]);
      r = sat16((acc >>> 8) + longint'(fc2_biases[n]));
      h2m[n] = (r < 0) ? 0 : r;
    end
    for (int n = 0; n < OUT_SIZE; n++) begin
      acc = 0;
      for (int k = 0; k < H2_SIZE; k++)
        acc += longint'(h2m[k]) * longint'(fc3_weights[n*H2_SIZE+k]);
      r = sat16((acc >>> 8) + longint'(fc3_biases[n]));
      res[n*16 +: 16] = 16'(r);
    end
  endtask

  task automatic clear_all();
    foreach (input_image[k]) input_image[k] = '0;
    foreach (fc1_weights[k]) fc1_weights[k] = '0;
    foreach (fc2_weights[k]) fc2_weights[k] = '0;
    foreach (fc3_weights[k]) fc3_weights[k] = '0;
    foreach (fc1_biases[k])  fc1_biases[k]  = '0;
    foreach (fc2_biases[k])  fc2_biases[k]  = '0;
    foreach (fc3_biases[k])  fc3_biases[k]  = '0;
  endtask

  task automatic check_outputs(input string tag, input logic [OUT_SIZE*16-1:0] req);
    for (int k = 0; k < OUT_SIZE; k++)
      chk($sformatf("%s_out%0d", tag, k), int'(output_result[k]),
          int'($signed(req[k*16 +: 16])));
  endtask

  // Monitor: pops one expected entry on each rising valid_out.
  initial begin
    logic prev_v;
    sb_entry_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (valid_out && !prev_v) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("latency_edge", cyc, e.due);
          check_outputs("result", e.res);
        end
      end
      prev_v = valid_out;
    end
  end

  task automatic run_inference(input string tag, input bit poke_l2);
    logic [OUT_SIZE*16-1:0] exp_res;
    sb_entry_t e;
    int e0;
    model(exp_res);
    last_exp = exp_res;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    e.due = e0 + LATENCY;
    e.res = exp_res;
    sb.push_back(e);
    chk({tag, "_start_clears_valid"}, int'(valid_out), 0);
    for (int t = 1; t <= LATENCY + 100 && sb.size() != 0; t++) begin
      @(negedge clk);
      if (t == 1) start = 1'b0;
      if (poke_l2 && t == 12700) start = 1'b1;
      if (poke_l2 && t == 12701) start = 1'b0;
    end
    if (sb.size() != 0) begin
      chk({tag, "_timeout_valid"}, 0, 1);
      sb.delete();
    end
    repeat (20) @(negedge clk);
    chk({tag, "_hold_valid"}, int'(valid_out), 1);
    check_outputs({tag, "_hold"}, exp_res);
  endtask

  initial begin
    clear_all();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", int'(valid_out), 0);
    check_outputs("reset", '0);
    rstN = 1'b1;

    // Zero weights: outputs are just the ramped layer-3 biases.
    clear_all();
    for (int k = 0; k < OUT_SIZE; k++) fc3_biases[k] = 16'(k * 256);
    run_inference("bias_ramp", 1'b0);

    // Pass-through with identity hidden layers; a stray start lands in L2.
    clear_all();
    input_image[0] = 16'h0100;
    for (int n = 0; n < H1_SIZE; n++) fc1_weights[n*IN_SIZE] = 16'h0100;
    for (int n = 0; n < H2_SIZE; n++) fc2_weights[n*H1_SIZE+n] = 16'h0100;
    for (int n = 0; n < OUT_SIZE; n++) fc3_weights[n*H2_SIZE+n] = 16'h0100;
    run_inference("passthru", 1'b1);

    // Saturation at every layer.
    clear_all();
    foreach (input_image[k]) input_image[k] = 16'sh7FFF;
    foreach (fc1_weights[k]) fc1_weights[k] = 16'sh7FFF;
    foreach (fc2_weights[k]) fc2_weights[k] = 16'h0100;
    foreach (fc3_weights[k]) fc3_weights[k] = 16'h0100;
    run_inference("saturate", 1'b0);

    // ReLU clamps hidden layers; negative layer-3 bias shows through.
    clear_all();
    input_image[0] = 16'h0100;
    for (int n = 0; n < H1_SIZE; n++) fc1_weights[n*IN_SIZE] = 16'h0100;
    foreach (fc1_biases[k])  fc1_biases[k]  = -16'sh0200;
    foreach (fc2_weights[k]) fc2_weights[k] = 16'h0100;
    foreach (fc3_weights[k]) fc3_weights[k] = 16'h0100;
    foreach (fc3_biases[k])  fc3_biases[k]  = -16'sd512;
    run_inference("relu_neg", 1'b0);

    // Reset in the middle of L1 discards the inference.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    repeat (499) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    rstN = 1'b0;
    @(negedge clk);
    chk("midreset_valid", int'(valid_out), 0);
    check_outputs("midreset", '0);
    rstN = 1'b1;

    // Random inference, then a restart from DONE with the same inputs.
    foreach (input_image[k]) input_image[k] = 16'(rnd(-256, 256));
    foreach (fc1_weights[k]) fc1_weights[k] = 16'(rnd(-48, 48));
    foreach (fc2_weights[k]) fc2_weights[k] = 16'(rnd(-256, 256));
    foreach (fc3_weights[k]) fc3_weights[k] = 16'(rnd(-256, 256));
    foreach (fc1_biases[k])  fc1_biases[k]  = 16'(rnd(-512, 512));
    foreach (fc2_biases[k])  fc2_biases[k]  = 16'(rnd(-512, 512));
    foreach (fc3_biases[k])  fc3_biases[k]  = 16'(rnd(-512, 512));
    run_inference("random", 1'b0);
    run_inference("restart", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
